// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves one S-bit slice using group lookahead; lower sum bits
// and unconsumed operand bits travel forward with the beat.
module cla_pipelined_adder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned GROUP       = 4,
    parameter int unsigned GRP_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned S    = GROUP * GRP_PER_STG;
    localparam int unsigned NSTG = WIDTH / S;

    if (WIDTH % S != 0) begin : g_bad_cfg
        $error("cla_pipelined_adder: WIDTH must be a multiple of GROUP*GRP_PER_STG");
    end

    logic             stall;
    logic             accept;

    logic             vld_q [NSTG];
    logic             vld_d [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] b_d   [NSTG];
    logic [WIDTH-1:0] sum_q [NSTG];
    logic [WIDTH-1:0] sum_d [NSTG];
    logic             cin_q [NSTG];
    logic             cin_d [NSTG];

    logic [S-1:0]     slc_sum  [NSTG];
    logic             slc_cout [NSTG];
    logic             slc_cmsb [NSTG];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q,   out_sum_d;
    logic             out_cout_q,  out_cout_d;
    logic             out_ovf_q,   out_ovf_d;
    logic             out_zero_q,  out_zero_d;

    // Global stall freezes the whole pipe while a result waits downstream.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~rst & ~stall;
    assign accept   = in_valid & in_ready;

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

    // Per-stage slice: group carries come from prefix G/P against the stage carry-in.
    always_comb begin
        logic [S-1:0] g;
        logic [S-1:0] p;
        logic         run_g;
        logic         run_p;
        logic         c_grp;
        logic         bit_g;
        logic         bit_p;
        logic         c_bit;
        g     = '0;
        p     = '0;
        run_g = 1'b0;
        run_p = 1'b1;
        c_grp = 1'b0;
        bit_g = 1'b0;
        bit_p = 1'b1;
        c_bit = 1'b0;
        for (int unsigned k = 0; k < NSTG; k++) begin
            slc_sum[k]  = '0;
            slc_cmsb[k] = 1'b0;
            g     = a_q[k][k*S +: S] & b_q[k][k*S +: S];
            p     = a_q[k][k*S +: S] ^ b_q[k][k*S +: S];
            run_g = 1'b0;
            run_p = 1'b1;
            for (int unsigned grp = 0; grp < GRP_PER_STG; grp++) begin
                c_grp = run_g | (run_p & cin_q[k]);
                bit_g = 1'b0;
                bit_p = 1'b1;
                for (int unsigned j = 0; j < GROUP; j++) begin
                    c_bit = bit_g | (bit_p & c_grp);
                    slc_sum[k][grp*GROUP + j] = p[grp*GROUP + j] ^ c_bit;
                    if (grp*GROUP + j == S - 1) begin
                        slc_cmsb[k] = c_bit;
                    end
                    bit_g = g[grp*GROUP + j] | (p[grp*GROUP + j] & bit_g);
                    bit_p = bit_p & p[grp*GROUP + j];
                end
                run_g = bit_g | (bit_p & run_g);
                run_p = run_p & bit_p;
            end
            slc_cout[k] = run_g | (run_p & cin_q[k]);
        end
    end

    // Next-state: hold everything on stall, otherwise shift the pipe by one.
    always_comb begin
        for (int unsigned k = 0; k < NSTG; k++) begin
            vld_d[k] = vld_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
            cin_d[k] = cin_q[k];
        end
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_zero_d  = out_zero_q;
        if (!stall) begin
            vld_d[0] = accept;
            if (accept) begin
                a_d[0]   = in_a;
                b_d[0]   = in_sub ? ~in_b : in_b;
                cin_d[0] = in_cin ^ in_sub;
                sum_d[0] = '0;
            end
            for (int unsigned k = 1; k < NSTG; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                cin_d[k] = slc_cout[k-1];
                sum_d[k] = sum_q[k-1];
                sum_d[k][(k-1)*S +: S] = slc_sum[k-1];
            end
            out_valid_d = vld_q[NSTG-1];
            if (vld_q[NSTG-1]) begin
                out_sum_d = sum_q[NSTG-1];
                out_sum_d[(NSTG-1)*S +: S] = slc_sum[NSTG-1];
                out_cout_d = slc_cout[NSTG-1];
                out_ovf_d  = slc_cmsb[NSTG-1] ^ slc_cout[NSTG-1];
                out_zero_d = ~|out_sum_d;
            end
        end
    end

    // Control and result registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                vld_q[k] <= vld_d[k];
            end
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
        end
    end

    // Datapath stage registers; qualified by the stage valids, so no reset needed.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NSTG; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
            cin_q[k] <= cin_d[k];
        end
    end

endmodule
